sa_result_collector: RTL and testbench
======================================

Name: sa_result_collector

Overview:
- Output-side partner of systolic_array_wrapper. Receives the 4-lane, 8-bit result stream the array shifts out, assembles one ROWS x LANES result matrix, then drains it row by row to an SRAM-side write port using a valid/ready handshake.
- Sits between the array's shift_out_* lanes and the result SRAM writer. It replaces manual bench-side collection of shift_out_0..3.

Parameters:
- DW, 8, width of one result element (one lane).
- LANES, 4, number of parallel result lanes (array columns).
- ROWS, 4, number of result beats per matrix.
- AW, 8, write address width.
- BASE_ADDR, 0, SRAM word address of row 0.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that arms capture of one matrix.
- shift_valid  in  1  array result lanes carry a valid beat this cycle.
- shift_in_0..shift_in_3  in  DW each  result lanes from the array's shift_out_0..3.
- wr_valid  out  1  write request valid.
- wr_ready  in  1  SRAM side accepts the write.
- wr_addr  out  AW  row word address.
- wr_data  out  LANES*DW  packed row {lane3,lane2,lane1,lane0}.
- busy  out  1  high in CAPTURE or DRAIN.
- done  out  1  one-cycle pulse after the last row is accepted.
- overrun  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rstn is asynchronous, active-low. While rstn=0: state=IDLE, counters=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0, overrun=0. Buffer contents are don't-care.
- FSM states are IDLE, CAPTURE, DRAIN, DONE.
- IDLE:
  - start=1 moves to CAPTURE next cycle, clears beat_cnt and overrun.
  - shift_valid is ignored in IDLE, including in the same cycle as start.
- CAPTURE:
  - Each cycle with shift_valid=1 stores the lanes into buf[beat_cnt][j] (lane j goes to column j) and increments beat_cnt.
  - Gaps in shift_valid are allowed.
  - When the ROWS-th beat is stored, the FSM moves to DRAIN on the next edge and row_cnt is set to 0.
  - start is ignored in CAPTURE.
- DRAIN:
  - wr_valid=1, wr_addr=BASE_ADDR+row_cnt (wraps modulo 2^AW), wr_data=packed buf[row_cnt].
  - Addr and data hold stable while wr_valid=1 and wr_ready=0.
  - On wr_valid&wr_ready, row_cnt increments. Back-to-back acceptance gives one row per cycle.
  - After row ROWS-1 is accepted, the FSM goes to DONE and wr_valid drops on that edge.
  - First wr_valid is asserted exactly 1 cycle after the last capture beat.
- DONE: done=1 for one cycle, then IDLE. start in DONE is ignored.
- busy=1 exactly in CAPTURE and DRAIN.
- Overrun: shift_valid=1 in DRAIN or DONE sets overrun, which stays set until the next accepted start. That data is dropped and the buffer is not modified.
- Simultaneous events: a capture beat and the state change are not in conflict; the last beat is stored on the same edge the FSM leaves CAPTURE.
- Reset asserted mid-operation aborts immediately. wr_valid drops asynchronously and no done is generated.
- Data is passed through unchanged: no arithmetic, no saturation.

Optional Feature:
- Macro SA_COLLECT_TRANSPOSE_EN.
- Defined: DRAIN emits columns instead of rows. Word k = {buf[3][k],buf[2][k],buf[1][k],buf[0][k]}, address BASE_ADDR+k, with LANES words. ROWS must equal LANES.
- Undefined: row-major drain as described above.
- All handshake, timing and flag behaviour is identical in both builds.

Decomposition:
- Package sa_pkg holds:
  - the state enum (IDLE, CAPTURE, DRAIN, DONE);
  - SA_DW=8, SA_LANES=4, SA_ROWS=4 constants;
  - the row pack function.
- One sub-module, sa_row_buffer: ROWS x LANES x DW register file with one write port (beat) and one combinational read port (row, or column under the macro).
- The FSM, counters and flags stay in sa_result_collector.

Test Plan:
- Basic capture: start; 4 beats of lanes 30,30,30,30 with wr_ready=1 -> writes addr 0..3, data 0x1E1E1E1E on 4 consecutive cycles; first wr_valid 1 cycle after the 4th beat; done pulses once; busy is high from the cycle after start until the last accept.
- Distinct rows: beats (96,104,112,120), (48,52,56,60), (48,52,56,60), (96,104,112,120) with gaps between beats, BASE_ADDR=0x10 -> addr 0x10 data 0x78706860, 0x11 0x3C383430, 0x12 0x3C383430, 0x13 0x78706860.
- Backpressure: same data with wr_ready toggling 0,0,1,0,1,1,1 -> addr and data stable while stalled; exactly 4 writes in order; done after the 4th accept.
- Overrun: shift_valid=1 (lanes 0xFF) during DRAIN -> overrun=1, drained data unchanged; next start clears overrun.
- Reset mid-DRAIN: rstn=0 after 2 writes -> wr_valid=0 and busy=0 immediately, no done; a fresh start then runs a clean 4-row capture from addr BASE_ADDR.
- Transpose build: second data set with SA_COLLECT_TRANSPOSE_EN -> addr 0x10 data 0x60303060, 0x11 0x68343468, 0x12 0x70383870, 0x13 0x783C3C78.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array result collector.
// SA_COLLECT_TRANSPOSE_EN selects column-major drain in sa_row_buffer.
package sa_pkg;

    localparam int SA_DW    = 8;
    localparam int SA_LANES = 4;
    localparam int SA_ROWS  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } sa_state_e;

    // Lane 0 lands in the least significant byte of the packed row.
    function automatic logic [SA_LANES*SA_DW-1:0] sa_pack_row(
        input logic [SA_DW-1:0] l0,
        input logic [SA_DW-1:0] l1,
        input logic [SA_DW-1:0] l2,
        input logic [SA_DW-1:0] l3
    );
        return {l3, l2, l1, l0};
    endfunction

endpackage

// File: rtl/sa_row_buffer.sv
// ROWS x LANES x DW result store: one row write port, one combinational read port.
// With SA_COLLECT_TRANSPOSE_EN the read port returns column raddr instead of row raddr.
module sa_row_buffer
    import sa_pkg::*;
#(
    parameter int DW    = SA_DW,
    parameter int LANES = SA_LANES,
    parameter int ROWS  = SA_ROWS,
    parameter int RW    = 2
) (
    input  logic                clk,
    input  logic                we,
    input  logic [RW-1:0]       waddr,
    input  logic [LANES*DW-1:0] wdata,
    input  logic [RW-1:0]       raddr,
    output logic [LANES*DW-1:0] rdata
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [LANES*DW-1:0] mem_q [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef SA_COLLECT_TRANSPOSE_EN
    // Word k gathers element k of every stored row; requires ROWS == LANES.
    always_comb begin
        rdata = '0;
        for (int j = 0; j < LANES; j++) begin
            rdata[j*DW +: DW] = mem_q[j][raddr*DW +: DW];
        end
    end
`else
    always_comb begin
        rdata = mem_q[raddr];
    end
`endif

endmodule

// File: rtl/sa_result_collector.sv
// Collects ROWS beats of the array's shift-out lanes and drains them to an SRAM write port.
// SA_COLLECT_TRANSPOSE_EN drains columns instead of rows; timing is identical.
module sa_result_collector
    import sa_pkg::*;
#(
    parameter int            DW        = SA_DW,
    parameter int            LANES     = SA_LANES,
    parameter int            ROWS      = SA_ROWS,
    parameter int            AW        = 8,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                shift_valid,
    input  logic [DW-1:0]       shift_in_0,
    input  logic [DW-1:0]       shift_in_1,
    input  logic [DW-1:0]       shift_in_2,
    input  logic [DW-1:0]       shift_in_3,
    output logic                wr_valid,
    input  logic                wr_ready,
    output logic [AW-1:0]       wr_addr,
    output logic [LANES*DW-1:0] wr_data,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output sa_state_e           dbg_state
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RW-1:0] LAST_IDX = RW'(ROWS - 1);

    sa_state_e           state_q, state_d;
    logic [RW-1:0]       beat_cnt_q, beat_cnt_d;
    logic [RW-1:0]       row_cnt_q, row_cnt_d;
    logic                overrun_q, overrun_d;
    logic                buf_we;
    logic [LANES*DW-1:0] beat_row;
    logic [LANES*DW-1:0] rd_row;

    assign beat_row = sa_pack_row(shift_in_0, shift_in_1, shift_in_2, shift_in_3);

    sa_row_buffer #(
        .DW    (DW),
        .LANES (LANES),
        .ROWS  (ROWS),
        .RW    (RW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (beat_cnt_q),
        .wdata (beat_row),
        .raddr (row_cnt_q),
        .rdata (rd_row)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            row_cnt_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            row_cnt_q  <= row_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    // Write handshake: a row transfers on any rising edge where wr_valid && wr_ready;
    // while wr_valid is high and wr_ready low, wr_addr/wr_data hold and wr_valid stays high.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        row_cnt_d  = row_cnt_q;
        overrun_d  = overrun_q;
        buf_we     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CAPTURE;
                    beat_cnt_d = '0;
                    overrun_d  = 1'b0;
                end
            end
            CAPTURE: begin
                if (shift_valid) begin
                    buf_we = 1'b1;
                    if (beat_cnt_q == LAST_IDX) begin
                        state_d    = DRAIN;
                        beat_cnt_d = '0;
                        row_cnt_d  = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (shift_valid) begin
                    overrun_d = 1'b1;
                end
                if (wr_ready) begin
                    if (row_cnt_q == LAST_IDX) begin
                        state_d   = DONE;
                        row_cnt_d = '0;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                if (shift_valid) begin
                    overrun_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode registered state, so an asynchronous reset clears them at once.
    assign wr_valid  = (state_q == DRAIN);
    assign wr_addr   = wr_valid ? (BASE_ADDR + AW'(row_cnt_q)) : '0;
    assign wr_data   = wr_valid ? rd_row : '0;
    assign busy      = (state_q == CAPTURE) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign overrun   = overrun_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sa_result_collector.sv
// Directed bench for sa_result_collector: two instances (BASE_ADDR 0x00 and 0x10) share stimulus.
// Expected drain words switch to column-major when SA_COLLECT_TRANSPOSE_EN is defined.
module tb_sa_result_collector;
    import sa_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        shift_valid;
    logic        wr_ready;
    logic [7:0]  sin0, sin1, sin2, sin3;

    logic        wr_valid0, wr_valid1;
    logic [7:0]  wr_addr0, wr_addr1;
    logic [31:0] wr_data0, wr_data1;
    logic        busy0, busy1, done0, done1, overrun0, overrun1;
    sa_state_e   dbg0, dbg1;

    int checks   = 0;
    int errors   = 0;
    int accepts  = 0;
    int done_cnt = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  exp_idx_q[$];
    logic [31:0] s2 [4];

    always #5 clk = ~clk;

    sa_result_collector #(.BASE_ADDR(8'h00)) u0 (
        .clk(clk), .rstn(rstn), .start(start), .shift_valid(shift_valid),
        .shift_in_0(sin0), .shift_in_1(sin1), .shift_in_2(sin2), .shift_in_3(sin3),
        .wr_valid(wr_valid0), .wr_ready(wr_ready), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .busy(busy0), .done(done0), .overrun(overrun0), .dbg_state(dbg0)
    );

    sa_result_collector #(.BASE_ADDR(8'h10)) u1 (
        .clk(clk), .rstn(rstn), .start(start), .shift_valid(shift_valid),
        .shift_in_0(sin0), .shift_in_1(sin1), .shift_in_2(sin2), .shift_in_3(sin3),
        .wr_valid(wr_valid1), .wr_ready(wr_ready), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .busy(busy1), .done(done1), .overrun(overrun1), .dbg_state(dbg1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        shift_valid = 1'b1;
        sin0 = a; sin1 = b; sin2 = c; sin3 = d;
        tick();
        shift_valid = 1'b0;
        sin0 = 8'h55; sin1 = 8'h55; sin2 = 8'h55; sin3 = 8'h55;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_rows(input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
        exp_q.push_back(d0); exp_idx_q.push_back(8'd0);
        exp_q.push_back(d1); exp_idx_q.push_back(8'd1);
        exp_q.push_back(d2); exp_idx_q.push_back(8'd2);
        exp_q.push_back(d3); exp_idx_q.push_back(8'd3);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done1 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("done_seen", {31'd0, done1}, 32'd1);
    endtask

    // Every cycle a write is offered, it must match the head of the expected queue.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (done1 === 1'b1) done_cnt++;
            if (wr_valid1 === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {31'd0, wr_valid1}, 32'd0);
                end else begin
                    chk("wr_data_u1", wr_data1, exp_q[0]);
                    chk("wr_addr_u1", {24'd0, wr_addr1}, 32'h10 + {24'd0, exp_idx_q[0]});
                    chk("wr_valid_u0", {31'd0, wr_valid0}, 32'd1);
                    chk("wr_data_u0", wr_data0, exp_q[0]);
                    chk("wr_addr_u0", {24'd0, wr_addr0}, {24'd0, exp_idx_q[0]});
                    if (wr_ready === 1'b1) begin
                        void'(exp_q.pop_front());
                        void'(exp_idx_q.pop_front());
                        accepts++;
                    end
                end
            end
        end
    end

    initial begin
        logic [6:0] pat;
`ifdef SA_COLLECT_TRANSPOSE_EN
        s2[0] = 32'h60303060; s2[1] = 32'h68343468; s2[2] = 32'h70383870; s2[3] = 32'h783C3C78;
`else
        s2[0] = 32'h78706860; s2[1] = 32'h3C383430; s2[2] = 32'h3C383430; s2[3] = 32'h78706860;
`endif
        rstn = 1'b0; start = 1'b0; shift_valid = 1'b0; wr_ready = 1'b1;
        sin0 = 8'h0; sin1 = 8'h0; sin2 = 8'h0; sin3 = 8'h0;
        repeat (3) tick();

        // Reset state
        chk("rst_wr_valid", {31'd0, wr_valid1}, 32'd0);
        chk("rst_busy",     {31'd0, busy1}, 32'd0);
        chk("rst_done",     {31'd0, done1}, 32'd0);
        chk("rst_overrun",  {31'd0, overrun1}, 32'd0);
        chk("rst_wr_addr",  {24'd0, wr_addr1}, 32'd0);
        chk("rst_wr_data",  wr_data1, 32'd0);
        chk("rst_state",    {30'd0, dbg1}, {30'd0, IDLE});
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Basic capture; shift_valid alongside start must be ignored
        push_rows(32'h1E1E1E1E, 32'h1E1E1E1E, 32'h1E1E1E1E, 32'h1E1E1E1E);
        shift_valid = 1'b1; sin0 = 8'hAA; sin1 = 8'hAA; sin2 = 8'hAA; sin3 = 8'hAA;
        do_start();
        shift_valid = 1'b0;
        chk("basic_busy_after_start", {31'd0, busy1}, 32'd1);
        chk("basic_state_capture", {30'd0, dbg1}, {30'd0, CAPTURE});
        chk("basic_no_overrun_idle", {31'd0, overrun1}, 32'd0);
        beat(8'd30, 8'd30, 8'd30, 8'd30);
        beat(8'd30, 8'd30, 8'd30, 8'd30);
        beat(8'd30, 8'd30, 8'd30, 8'd30);
        chk("basic_no_valid_in_capture", {31'd0, wr_valid1}, 32'd0);
        beat(8'd30, 8'd30, 8'd30, 8'd30);
        chk("basic_first_valid", {31'd0, wr_valid1}, 32'd1);
        chk("basic_busy_drain", {31'd0, busy1}, 32'd1);
        repeat (4) tick();
        chk("basic_done_pulse", {31'd0, done1}, 32'd1);
        chk("basic_busy_low", {31'd0, busy1}, 32'd0);
        chk("basic_valid_low", {31'd0, wr_valid1}, 32'd0);
        tick();
        chk("basic_done_one_cycle", {31'd0, done1}, 32'd0);
        chk("basic_state_idle", {30'd0, dbg1}, {30'd0, IDLE});
        chk("basic_accepts", accepts, 32'd4);
        chk("basic_done_cnt", done_cnt, 32'd1);

        // Distinct rows with gaps between beats
        push_rows(s2[0], s2[1], s2[2], s2[3]);
        do_start();
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        tick(); tick();
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        tick();
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        tick();
        chk("gap_no_valid", {31'd0, wr_valid1}, 32'd0);
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        chk("gap_first_valid", {31'd0, wr_valid1}, 32'd1);
        wait_done();
        tick();
        chk("gap_accepts", accepts, 32'd8);
        chk("gap_done_cnt", done_cnt, 32'd2);

        // Backpressure with wr_ready 0,0,1,0,1,1,1
        push_rows(s2[0], s2[1], s2[2], s2[3]);
        do_start();
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        wr_ready = 1'b0;
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        pat = 7'b1110100;
        for (int i = 0; i < 7; i++) begin
            chk("bp_valid_held", {31'd0, wr_valid1}, 32'd1);
            wr_ready = pat[i];
            tick();
        end
        chk("bp_done", {31'd0, done1}, 32'd1);
        wr_ready = 1'b1;
        tick();
        chk("bp_accepts", accepts, 32'd12);
        chk("bp_done_cnt", done_cnt, 32'd3);

        // Overrun: beats during DRAIN are flagged and dropped
        push_rows(s2[0], s2[1], s2[2], s2[3]);
        do_start();
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        wr_ready = 1'b0;
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        shift_valid = 1'b1; sin0 = 8'hFF; sin1 = 8'hFF; sin2 = 8'hFF; sin3 = 8'hFF;
        tick(); tick();
        shift_valid = 1'b0;
        chk("ovr_set", {31'd0, overrun1}, 32'd1);
        wr_ready = 1'b1;
        wait_done();
        tick();
        chk("ovr_sticky", {31'd0, overrun1}, 32'd1);
        chk("ovr_accepts", accepts, 32'd16);
        push_rows(32'h1E1E1E1E, 32'h1E1E1E1E, 32'h1E1E1E1E, 32'h1E1E1E1E);
        do_start();
        chk("ovr_cleared_by_start", {31'd0, overrun1}, 32'd0);
        repeat (4) beat(8'd30, 8'd30, 8'd30, 8'd30);
        wait_done();
        tick();
        chk("ovr_clean_accepts", accepts, 32'd20);
        chk("ovr_done_cnt", done_cnt, 32'd5);

        // Reset mid-DRAIN after two writes
        push_rows(s2[0], s2[1], s2[2], s2[3]);
        do_start();
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        tick(); tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("rstmid_valid_u1", {31'd0, wr_valid1}, 32'd0);
        chk("rstmid_valid_u0", {31'd0, wr_valid0}, 32'd0);
        chk("rstmid_busy", {31'd0, busy1}, 32'd0);
        chk("rstmid_accepts", accepts, 32'd22);
        exp_q.delete();
        exp_idx_q.delete();
        repeat (3) tick();
        chk("rstmid_no_done", {31'd0, done1}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("rstmid_done_cnt", done_cnt, 32'd5);
        push_rows(s2[0], s2[1], s2[2], s2[3]);
        do_start();
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        beat(8'd48, 8'd52, 8'd56, 8'd60);
        beat(8'd96, 8'd104, 8'd112, 8'd120);
        chk("rstmid_fresh_addr", {24'd0, wr_addr1}, 32'h10);
        wait_done();
        tick();
        chk("rstmid_fresh_accepts", accepts, 32'd26);
        chk("rstmid_fresh_done_cnt", done_cnt, 32'd6);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
